ped_request_conditioner: RTL and testbench

Upstream stage of the traffic light controller. It conditions the raw pedestrian push-button into a clean, held request, and drives the controller's pedestrian-request input. It synchronises and debounces the button, then latches one request and holds it until the controller grants the crossing. After each crossing it enforces a minimum gap and defers any press made during that gap.

---
 rtl/ped_request_conditioner_if.sv | 27 ++
 rtl/ped_request_conditioner.sv | 140 ++++++++++++++
 tb/tb_ped_request_conditioner.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ped_request_conditioner_if.sv
// Pedestrian request bus between the push-button conditioner and its user.
// master drives the raw button and the crossing grant, slave is the conditioner.
interface ped_request_conditioner_if #(
  parameter int COUNT_W = 8
);
  logic               button_raw;
  logic               ped_allow;
  logic               ped_req;
  logic               req_pending;
  logic [COUNT_W-1:0] press_count;

  modport master (
    output button_raw,
    output ped_allow,
    input  ped_req,
    input  req_pending,
    input  press_count
  );

  modport slave (
    input  button_raw,
    input  ped_allow,
    output ped_req,
    output req_pending,
    output press_count
  );
endinterface

// File: rtl/ped_request_conditioner.sv
// Pedestrian request conditioner: synchronises and debounces the push-button,
// holds one request until the crossing is granted, then enforces a minimum gap
// after each crossing, deferring any press made during that gap.
module ped_request_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int MIN_GAP_CYCLES  = 20,
  parameter int COUNT_W         = 8
) (
  input logic clk,
  input logic reset,
  ped_request_conditioner_if.slave bus
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GAP_W = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SERVING,
    LOCKOUT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  logic                   db;
  logic                   db_d;
  logic [DB_W-1:0]        db_count;
  logic                   press;

  state_t                 state;
  state_t                 state_next;
  logic                   deferred;
  logic                   deferred_next;
  logic [GAP_W-1:0]       gap_count;
  logic [GAP_W-1:0]       gap_next;
  logic                   count_inc;
  logic [COUNT_W-1:0]     press_count;

  assign sync  = sync_chain[SYNC_STAGES-1];
  assign press = db & ~db_d;

  // Shift the asynchronous button level through the synchroniser flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], bus.button_raw};
    end
  end

  // Debounce: the level only changes after an unbroken run of differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db       <= 1'b0;
      db_d     <= 1'b0;
      db_count <= '0;
    end else begin
      db_d <= db;
      if (sync != db) begin
        if (db_count == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db       <= ~db;
          db_count <= '0;
        end else begin
          db_count <= db_count + DB_W'(1);
        end
      end else begin
        db_count <= '0;
      end
    end
  end

  // Request state, deferral flag, gap timer and the saturating press counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      deferred    <= 1'b0;
      gap_count   <= '0;
      press_count <= '0;
    end else begin
      state     <= state_next;
      deferred  <= deferred_next;
      gap_count <= gap_next;
      if (count_inc && (press_count != {COUNT_W{1'b1}})) begin
        press_count <= press_count + COUNT_W'(1);
      end
    end
  end

  // Next-state logic: presses are accepted when idle, merged while pending,
  // dropped while the crossing is in progress and deferred during the gap.
  always_comb begin
    state_next    = state;
    deferred_next = deferred;
    gap_next      = gap_count;
    count_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          state_next = PENDING;
          count_inc  = 1'b1;
        end
      end
      PENDING: begin
        if (bus.ped_allow) begin
          state_next = SERVING;
        end
      end
      SERVING: begin
        if (!bus.ped_allow) begin
          state_next = LOCKOUT;
          gap_next   = GAP_W'(MIN_GAP_CYCLES - 1);
        end
      end
      LOCKOUT: begin
        if (gap_count == '0) begin
          state_next    = (deferred || press) ? PENDING : IDLE;
          deferred_next = 1'b0;
          count_inc     = press & ~deferred;
        end else begin
          gap_next = gap_count - GAP_W'(1);
          if (press) begin
            deferred_next = 1'b1;
            count_inc     = ~deferred;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        deferred_next = 1'b0;
      end
    endcase
  end

  assign bus.ped_req     = (state == PENDING);
  assign bus.req_pending = (state == PENDING) | deferred;
  assign bus.press_count = press_count;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Self-checking bench for ped_request_conditioner: directed vector table,
// hand-timed gap corner cases, saturation, reset behaviour and random stimulus
// compared every cycle against a behavioural model.
module tb_ped_request_conditioner;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int MIN_GAP_CYCLES  = 20;
  localparam int COUNT_W         = 8;
  localparam int COUNT_MAX       = (1 << COUNT_W) - 1;

  localparam int PH_IDLE     = 0;
  localparam int PH_WAITING  = 1;
  localparam int PH_CROSSING = 2;
  localparam int PH_GAP      = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ped_request_conditioner_if #(.COUNT_W(COUNT_W)) bus ();

  ped_request_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .MIN_GAP_CYCLES (MIN_GAP_CYCLES),
    .COUNT_W        (COUNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int compared = 0;
  int failed   = 0;

  // Behavioural model: raw samples queue for the synchroniser, a disagreement
  // run length for the debouncer, and a phase plus remaining gap cycles.
  bit raw_q[$];
  bit m_sync;
  bit m_db;
  bit m_db_prev;
  int m_run;
  int m_phase;
  int m_lock_left;
  bit m_deferred;
  int m_count;

  typedef struct {
    bit    rst;
    bit    button;
    bit    allow;
    int    cycles;
    bit    exp_req;
    bit    exp_pend;
    int    exp_count;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit button, input bit allow);
    bus.button_raw = button;
    bus.ped_allow  = allow;
  endtask

  function automatic void model_reset();
    raw_q.delete();
    m_sync      = 1'b0;
    m_db        = 1'b0;
    m_db_prev   = 1'b0;
    m_run       = 0;
    m_phase     = PH_IDLE;
    m_lock_left = 0;
    m_deferred  = 1'b0;
    m_count     = 0;
  endfunction

  function automatic void bump();
    if (m_count < COUNT_MAX) m_count++;
  endfunction

  function automatic void model_step(input bit raw, input bit allow);
    bit press;
    press = m_db && !m_db_prev;
    if (m_phase == PH_IDLE) begin
      if (press) begin
        m_phase = PH_WAITING;
        bump();
      end
    end else if (m_phase == PH_WAITING) begin
      if (allow) m_phase = PH_CROSSING;
    end else if (m_phase == PH_CROSSING) begin
      if (!allow) begin
        m_phase     = PH_GAP;
        m_lock_left = MIN_GAP_CYCLES;
      end
    end else begin
      if (m_lock_left == 1) begin
        if (press && !m_deferred) bump();
        m_phase    = (m_deferred || press) ? PH_WAITING : PH_IDLE;
        m_deferred = 1'b0;
      end else begin
        m_lock_left--;
        if (press) begin
          if (!m_deferred) bump();
          m_deferred = 1'b1;
        end
      end
    end
    m_db_prev = m_db;
    if (m_sync != m_db) begin
      m_run++;
      if (m_run == DEBOUNCE_CYCLES) begin
        m_db  = !m_db;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    raw_q.push_back(raw);
    if (raw_q.size() > SYNC_STAGES) void'(raw_q.pop_front());
    m_sync = (raw_q.size() == SYNC_STAGES) ? raw_q[0] : 1'b0;
  endfunction

  task automatic compare_model();
    checkOutput("model ped_req", bus.ped_req, (m_phase == PH_WAITING));
    checkOutput("model req_pending", bus.req_pending, (m_phase == PH_WAITING) || m_deferred);
    checkOutput("model press_count", bus.press_count, m_count);
  endtask

  task automatic tick();
    bit b;
    bit a;
    b = bus.button_raw;
    a = bus.ped_allow;
    @(posedge clk);
    if (!reset) model_step(b, a);
    #1;
    compare_model();
  endtask

  task automatic check_all(input string name, input bit req, input bit pend, input int cnt);
    checkOutput({name, " ped_req"}, bus.ped_req, req);
    checkOutput({name, " req_pending"}, bus.req_pending, pend);
    checkOutput({name, " press_count"}, bus.press_count, cnt);
  endtask

  // Asserts reset mid-cycle, checks the outputs clear without a clock edge,
  // then releases it one cycle later just after a rising edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async reset", 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic add_vec(input bit rst, input bit button, input bit allow, input int cycles,
                         input bit req, input bit pend, input int cnt, input string name);
    vec_t v;
    v.rst = rst; v.button = button; v.allow = allow; v.cycles = cycles;
    v.exp_req = req; v.exp_pend = pend; v.exp_count = cnt; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    int b_left;
    int a_left;
    bit btn;
    bit alw;

    applyStimulus(1'b0, 1'b0);
    model_reset();

    add_vec(1, 0, 0, 0,  0, 0, 0, "reset");
    add_vec(0, 1, 0, 5,  0, 0, 0, "bounce hi5");
    add_vec(0, 0, 0, 3,  0, 0, 0, "bounce lo3");
    add_vec(0, 1, 0, 7,  0, 0, 0, "bounce hi7");
    add_vec(0, 0, 0, 12, 0, 0, 0, "bounce settle");
    add_vec(1, 0, 0, 0,  0, 0, 0, "reset2");
    add_vec(0, 1, 0, 10, 0, 0, 0, "latency edge10");
    add_vec(0, 1, 0, 1,  1, 1, 1, "latency edge11");
    add_vec(0, 1, 1, 1,  0, 0, 1, "grant");
    add_vec(0, 0, 1, 14, 0, 0, 1, "serving");
    for (int i = 0; i < 3; i++) begin
      add_vec(0, 1, 1, 12, 0, 0, 1, "serving press");
      add_vec(0, 0, 1, 12, 0, 0, 1, "serving release");
    end
    add_vec(0, 0, 0, 1,  0, 0, 1, "lockout entry");
    add_vec(0, 0, 0, 19, 0, 0, 1, "lockout");
    add_vec(0, 0, 0, 1,  0, 0, 1, "back to idle");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].button, vecs[i].allow);
      if (vecs[i].rst) begin
        do_reset();
      end else begin
        repeat (vecs[i].cycles) tick();
      end
      check_all(vecs[i].name, vecs[i].exp_req, vecs[i].exp_pend, vecs[i].exp_count);
    end

    // Press made during the gap is deferred and served right after it.
    applyStimulus(1'b1, 1'b0);
    repeat (11) tick();
    check_all("second request", 1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1);
    tick();
    check_all("req drops on grant", 1'b0, 1'b0, 2);
    repeat (14) tick();
    applyStimulus(1'b1, 1'b0);
    repeat (10) tick();
    check_all("gap before press", 1'b0, 1'b0, 2);
    tick();
    check_all("gap press deferred", 1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0);
    repeat (9) tick();
    check_all("gap cycle 20", 1'b0, 1'b1, 3);
    tick();
    check_all("deferred served", 1'b1, 1'b1, 3);

    // Press arriving on the very cycle the gap expires.
    applyStimulus(1'b0, 1'b1);
    repeat (13) tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    repeat (9) tick();
    applyStimulus(1'b1, 1'b0);
    repeat (10) tick();
    check_all("gap end pre-press", 1'b0, 1'b0, 3);
    tick();
    check_all("press at gap end", 1'b1, 1'b1, 4);

    // Reset with a deferred request outstanding, button held across release.
    applyStimulus(1'b0, 1'b1);
    repeat (13) tick();
    applyStimulus(1'b1, 1'b0);
    repeat (13) tick();
    check_all("deferred before reset", 1'b0, 1'b1, 5);
    do_reset();
    repeat (10) tick();
    check_all("held button edge10", 1'b0, 1'b0, 0);
    tick();
    check_all("held button edge11", 1'b1, 1'b1, 1);

    // Saturation of the press counter.
    applyStimulus(1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0);
      repeat (12) tick();
      applyStimulus(1'b0, 1'b1);
      repeat (12) tick();
      applyStimulus(1'b0, 1'b0);
      repeat (22) tick();
    end
    checkOutput("saturated count", bus.press_count, COUNT_MAX);

    // Random bouncy button and grant traffic against the model.
    applyStimulus(1'b0, 1'b0);
    do_reset();
    b_left = 0;
    a_left = 0;
    btn = 1'b0;
    alw = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (b_left == 0) begin
        btn = 1'($urandom_range(0, 1));
        b_left = $urandom_range(1, 14);
      end
      if (a_left == 0) begin
        alw = 1'($urandom_range(0, 1));
        a_left = $urandom_range(1, 30);
      end
      applyStimulus(btn, alw);
      tick();
      b_left--;
      a_left--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
